// File: rtl/aq_djpeg_ycbcr_reader_if.sv
// aq_djpeg_ycbcr_reader_if
// Groups the reader's two handshake sides into one bundle:
//   - YCbCr MCU buffer side: DataOutEnable, DataOutAddressY/CbCr,
//     DataOutRead, DataOutReadNext, DataOutY/Cb/Cr.
//   - Colour-conversion side: OutEnable/OutReady handshake, OutPixelX/Y,
//     OutY/Cb/Cr, OutLast.
// Modports:
//   master - the reader (drives buffer addresses and the pixel stream)
//   slave  - the environment (buffer plus downstream consumer)
interface aq_djpeg_ycbcr_reader_if;
  logic        DataOutEnable;
  logic [7:0]  DataOutAddressY;
  logic [7:0]  DataOutAddressCbCr;
  logic        DataOutRead;
  logic        DataOutReadNext;
  logic [8:0]  DataOutY;
  logic [8:0]  DataOutCb;
  logic [8:0]  DataOutCr;
  logic        OutEnable;
  logic        OutReady;
  logic [15:0] OutPixelX;
  logic [15:0] OutPixelY;
  logic [8:0]  OutY;
  logic [8:0]  OutCb;
  logic [8:0]  OutCr;
  logic        OutLast;

  modport master (
    input  DataOutEnable, DataOutY, DataOutCb, DataOutCr, OutReady,
    output DataOutAddressY, DataOutAddressCbCr, DataOutRead, DataOutReadNext,
    output OutEnable, OutPixelX, OutPixelY, OutY, OutCb, OutCr, OutLast
  );

  modport slave (
    output DataOutEnable, DataOutY, DataOutCb, DataOutCr, OutReady,
    input  DataOutAddressY, DataOutAddressCbCr, DataOutRead, DataOutReadNext,
    input  OutEnable, OutPixelX, OutPixelY, OutY, OutCb, OutCr, OutLast
  );
endinterface

// File: rtl/aq_djpeg_ycbcr_reader.sv
// aq_djpeg_ycbcr_reader
// Read-side sequencer for the JPEG decoder's YCbCr MCU buffer. Waits for a
// filled bank, walks the 16x16 MCU in raster order, streams pixels tagged
// with image coordinates to the colour-conversion stage, drops pixels that
// fall outside the image and releases each bank with a one-cycle pulse.
// Ports:
//   clk, rst          - clock; asynchronous active-low reset
//   i_DataInit        - synchronous restart for a new image (highest priority)
//   i_JpegComp        - 3 = YCbCr 4:2:0, 1 = grayscale (chroma forced to 128)
//   i_ImageWidth/Height - image size in pixels, stable between restarts
//   o_Busy            - high while an MCU is being read or drained
//   bus               - buffer read port and pixel stream (master side)
module aq_djpeg_ycbcr_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_DataInit,
  input  logic [2:0]  i_JpegComp,
  input  logic [15:0] i_ImageWidth,
  input  logic [15:0] i_ImageHeight,
  output logic        o_Busy,
  aq_djpeg_ycbcr_reader_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_cnt;
  logic [11:0] r_mcuX;
  logic [11:0] r_mcuY;
  logic        r_rdValid;
  logic        r_rdClip;
  logic [15:0] r_px;
  logic [15:0] r_py;

  logic        w_advance;
  logic        w_issue;
  logic        w_release;
  logic [16:0] w_mcuXEnd;
  logic [16:0] w_mcuYEnd;
  logic        w_lastCol;
  logic        w_lastRow;
  logic        w_lastMcu;
  logic [15:0] w_px;
  logic [15:0] w_py;

  // The pipeline slot may move when it is empty, being consumed, or holds a
  // clipped pixel that nobody downstream will ever accept.
  assign w_advance = !r_rdValid | bus.OutReady | r_rdClip;
  assign w_issue   = (r_state == S_RUN) & w_advance & !i_DataInit;
  assign w_release = (r_state == S_DRAIN) & w_advance & !i_DataInit;

  // MCU edges computed in 17 bits so a 4095th MCU does not wrap to zero.
  assign w_mcuXEnd = ({5'd0, r_mcuX} + 17'd1) << 4;
  assign w_mcuYEnd = ({5'd0, r_mcuY} + 17'd1) << 4;
  assign w_lastCol = w_mcuXEnd >= {1'b0, i_ImageWidth};
  assign w_lastRow = w_mcuYEnd >= {1'b0, i_ImageHeight};
  assign w_lastMcu = w_lastCol & w_lastRow;

  // McuX*16 + col is a plain concatenation since col is 4 bits wide.
  assign w_px = {r_mcuX, r_cnt[3:0]};
  assign w_py = {r_mcuY, r_cnt[7:4]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // Next-state logic; a restart overrides everything.
  always_comb begin
    w_nextState = r_state;
    if (i_DataInit) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.DataOutEnable) w_nextState = S_RUN;
        S_RUN:   if (w_issue && r_cnt == 8'hFF) w_nextState = S_DRAIN;
        S_DRAIN: if (w_advance) w_nextState = w_lastMcu ? S_DONE : S_IDLE;
        default: w_nextState = r_state;
      endcase
    end
  end

  // FSM-decoded outputs.
  always_comb begin
    bus.DataOutRead     = w_issue;
    bus.DataOutReadNext = w_release;
    o_Busy              = (r_state == S_RUN) || (r_state == S_DRAIN);
  end

  // Sample counter, MCU position and the one-deep read pipeline tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 8'd0;
      r_mcuX    <= 12'd0;
      r_mcuY    <= 12'd0;
      r_rdValid <= 1'b0;
      r_rdClip  <= 1'b0;
      r_px      <= 16'd0;
      r_py      <= 16'd0;
    end else if (i_DataInit) begin
      r_cnt     <= 8'd0;
      r_mcuX    <= 12'd0;
      r_mcuY    <= 12'd0;
      r_rdValid <= 1'b0;
      r_rdClip  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.DataOutEnable) r_cnt <= 8'd0;
      else if (w_issue)                           r_cnt <= r_cnt + 8'd1;

      if (w_issue) begin
        r_rdValid <= 1'b1;
        r_px      <= w_px;
        r_py      <= w_py;
        r_rdClip  <= (w_px >= i_ImageWidth) | (w_py >= i_ImageHeight);
      end else if (w_advance) begin
        r_rdValid <= 1'b0;
      end

      // Step to the next MCU in image raster order as the bank is released.
      if (w_release) begin
        if (w_lastCol) begin
          r_mcuX <= 12'd0;
          r_mcuY <= r_mcuY + 12'd1;
        end else begin
          r_mcuX <= r_mcuX + 12'd1;
        end
      end
    end
  end

  assign bus.DataOutAddressY    = r_cnt;
  assign bus.DataOutAddressCbCr = r_cnt;

  assign bus.OutEnable = r_rdValid & !r_rdClip;
  assign bus.OutPixelX = r_px;
  assign bus.OutPixelY = r_py;
  assign bus.OutY      = bus.DataOutY;
  assign bus.OutCb     = (i_JpegComp == 3'd1) ? 9'd128 : bus.DataOutCb;
  assign bus.OutCr     = (i_JpegComp == 3'd1) ? 9'd128 : bus.DataOutCr;
  assign bus.OutLast   = bus.OutEnable
                       & (r_px == i_ImageWidth - 16'd1)
                       & (r_py == i_ImageHeight - 16'd1);

endmodule

// File: tb/tb_aq_djpeg_ycbcr_reader.sv
// tb_aq_djpeg_ycbcr_reader
// Drives aq_djpeg_ycbcr_reader with a modelled MCU buffer and a random or
// always-ready consumer, and checks the pixel stream against an expected
// pixel list built from image geometry.
module tb_aq_djpeg_ycbcr_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        DataInit;
  logic [2:0]  JpegComp;
  logic [15:0] ImageWidth;
  logic [15:0] ImageHeight;
  logic        Busy;

  aq_djpeg_ycbcr_reader_if bus();

  aq_djpeg_ycbcr_reader dut (
    .clk          (clk),
    .rst          (rst),
    .i_DataInit   (DataInit),
    .i_JpegComp   (JpegComp),
    .i_ImageWidth (ImageWidth),
    .i_ImageHeight(ImageHeight),
    .o_Busy       (Busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int yv;
    int cb;
    int cr;
    int last;
  } pix_t;

  pix_t expQ[$];
  pix_t e;
  int   tests = 0;
  int   fails = 0;
  int   salt = 0;
  int   bank;
  int   acceptCount = 0;
  int   rnCount = 0;
  int   lastCount = 0;
  int   lastX = -1;
  int   lastY = -1;
  int   firstEnCycle = -1;
  int   firstRnCycle = -1;
  bit   readyRandom = 0;
  bit   holdPrev = 0;
  int   heldX, heldY, heldYv, heldCb, heldCr, heldLast, heldRead;

  // Buffer content is a hash of bank number and sample position.
  function automatic int fY(int b, int a);
    return ((b * 73 + a * 11 + salt) ^ (a >> 2)) & 511;
  endfunction

  function automatic int fC(int b, int s, int which);
    return (b * 29 + s * 7 + which * 151 + salt * 3) & 511;
  endfunction

  // The buffer subsamples chroma: one CbCr sample per 2x2 luma block.
  function automatic int subAddr(logic [7:0] a);
    return int'(a[7:5]) * 8 + int'(a[3:1]);
  endfunction

  // Buffer model: read register loads on DataOutRead, bank advances on release.
  always @(posedge clk) begin
    if (bus.DataOutRead) begin
      bus.DataOutY  <= 9'(fY(bank, int'(bus.DataOutAddressY)));
      bus.DataOutCb <= 9'(fC(bank, subAddr(bus.DataOutAddressCbCr), 0));
      bus.DataOutCr <= 9'(fC(bank, subAddr(bus.DataOutAddressCbCr), 1));
    end
    if (DataInit)                 bank <= 0;
    else if (bus.DataOutReadNext) bank <= bank + 1;
  end

  // Consumer readiness, changed just after each rising edge.
  initial begin
    bus.OutReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.OutReady = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Expected pixel list: MCUs in image raster order, pixels in raster order
  // inside each MCU, keeping only those inside the image.
  task automatic buildImage(input int w, input int h, input int comp);
    int mcuCols;
    int mcuRows;
    int m;
    pix_t p;
    mcuCols = (w + 15) / 16;
    mcuRows = (h + 15) / 16;
    m = 0;
    expQ.delete();
    for (int my = 0; my < mcuRows; my++) begin
      for (int mx = 0; mx < mcuCols; mx++) begin
        for (int r = 0; r < 16; r++) begin
          for (int c = 0; c < 16; c++) begin
            p.x = mx * 16 + c;
            p.y = my * 16 + r;
            if (p.x < w && p.y < h) begin
              p.yv   = fY(m, r * 16 + c);
              p.cb   = (comp == 1) ? 128 : fC(m, (r / 2) * 8 + c / 2, 0);
              p.cr   = (comp == 1) ? 128 : fC(m, (r / 2) * 8 + c / 2, 1);
              p.last = (p.x == w - 1 && p.y == h - 1) ? 1 : 0;
              expQ.push_back(p);
            end
          end
        end
        m++;
      end
    end
  endtask

  // Restart the DUT on a new image and rebuild the expectation.
  task automatic applyStimulus(input int w, input int h, input int comp);
    @(posedge clk);
    #1;
    DataInit          = 1'b1;
    ImageWidth        = 16'(w);
    ImageHeight       = 16'(h);
    JpegComp          = 3'(comp);
    bus.DataOutEnable = 1'b1;
    @(negedge clk);
    checkOutput("initNoReadNext", int'(bus.DataOutReadNext), 0);
    checkOutput("initNoRead", int'(bus.DataOutRead), 0);
    @(posedge clk);
    #1;
    DataInit    = 1'b0;
    salt        = int'($urandom_range(0, 511));
    acceptCount = 0;
    rnCount     = 0;
    lastCount   = 0;
    lastX       = -1;
    lastY       = -1;
    buildImage(w, h, comp);
  endtask

  // Cycle 0 is the first negedge after the restart, the idle sampling cycle.
  task automatic waitDone(input int maxCycles);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    firstEnCycle = -1;
    firstRnCycle = -1;
    while (!done && cyc < maxCycles) begin
      @(negedge clk);
      if (bus.OutEnable && firstEnCycle < 0)       firstEnCycle = cyc;
      if (bus.DataOutReadNext && firstRnCycle < 0) firstRnCycle = cyc;
      if (expQ.size() == 0 && !Busy) done = 1;
      cyc++;
    end
    checkOutput("finishInTime", int'(done), 1);
  endtask

  // Scoreboard and hold-stability checks on every mid-cycle sample.
  always @(negedge clk) begin
    if (rst) begin
      if (holdPrev) begin
        tests++;
        if (!bus.OutEnable || int'(bus.OutPixelX) != heldX || int'(bus.OutPixelY) != heldY ||
            int'(bus.OutY) != heldYv || int'(bus.OutCb) != heldCb || int'(bus.OutCr) != heldCr ||
            int'(bus.OutLast) != heldLast || heldRead != 0) begin
          fails++;
          $display("[TB] FAIL holdStable: got en=%0d (%0d,%0d) Y=%0d Cb=%0d Cr=%0d L=%0d rd=%0d expected held (%0d,%0d) Y=%0d Cb=%0d Cr=%0d L=%0d rd=0",
                   bus.OutEnable, bus.OutPixelX, bus.OutPixelY, bus.OutY, bus.OutCb, bus.OutCr,
                   bus.OutLast, heldRead, heldX, heldY, heldYv, heldCb, heldCr, heldLast);
        end
      end
      if (bus.DataOutReadNext) rnCount++;
      if (bus.OutEnable && bus.OutReady) begin
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL extraPixel: got (%0d,%0d) expected no pixel", bus.OutPixelX, bus.OutPixelY);
        end else begin
          e = expQ.pop_front();
          if (int'(bus.OutPixelX) != e.x || int'(bus.OutPixelY) != e.y || int'(bus.OutY) != e.yv ||
              int'(bus.OutCb) != e.cb || int'(bus.OutCr) != e.cr || int'(bus.OutLast) != e.last) begin
            fails++;
            $display("[TB] FAIL pixel: got (%0d,%0d) Y=%0d Cb=%0d Cr=%0d L=%0d expected (%0d,%0d) Y=%0d Cb=%0d Cr=%0d L=%0d",
                     bus.OutPixelX, bus.OutPixelY, bus.OutY, bus.OutCb, bus.OutCr, bus.OutLast,
                     e.x, e.y, e.yv, e.cb, e.cr, e.last);
          end
          acceptCount++;
          if (bus.OutLast) begin
            lastCount++;
            lastX = int'(bus.OutPixelX);
            lastY = int'(bus.OutPixelY);
          end
        end
      end
      holdPrev = bus.OutEnable && !bus.OutReady;
      heldX    = int'(bus.OutPixelX);
      heldY    = int'(bus.OutPixelY);
      heldYv   = int'(bus.OutY);
      heldCb   = int'(bus.OutCb);
      heldCr   = int'(bus.OutCr);
      heldLast = int'(bus.OutLast);
      heldRead = int'(bus.DataOutRead);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    fails++;
    $display("[TB] FAIL watchdog: got time limit expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int  reads;
    bit  gotRn;
    rst               = 1'b0;
    DataInit          = 1'b0;
    JpegComp          = 3'd3;
    ImageWidth        = 16'd16;
    ImageHeight       = 16'd16;
    bus.DataOutEnable = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstRead", int'(bus.DataOutRead), 0);
    checkOutput("rstReadNext", int'(bus.DataOutReadNext), 0);
    checkOutput("rstOutEnable", int'(bus.OutEnable), 0);
    checkOutput("rstOutLast", int'(bus.OutLast), 0);
    checkOutput("rstBusy", int'(Busy), 0);
    checkOutput("rstPixelX", int'(bus.OutPixelX), 0);
    checkOutput("rstPixelY", int'(bus.OutPixelY), 0);
    checkOutput("rstAddrY", int'(bus.DataOutAddressY), 0);
    checkOutput("rstAddrCbCr", int'(bus.DataOutAddressCbCr), 0);
    rst = 1'b1;

    // 16x16 YCbCr, always ready
    applyStimulus(16, 16, 3);
    waitDone(2000);
    checkOutput("t1Pixels", acceptCount, 256);
    checkOutput("t1ReadNextCount", rnCount, 1);
    checkOutput("t1ReadNextCycle", firstRnCycle, 257);
    checkOutput("t1FirstValidCycle", firstEnCycle, 2);
    checkOutput("t1LastCount", lastCount, 1);
    checkOutput("t1LastX", lastX, 15);
    checkOutput("t1LastY", lastY, 15);
    repeat (5) @(negedge clk);
    checkOutput("t1DoneBusy", int'(Busy), 0);
    checkOutput("t1DoneRead", int'(bus.DataOutRead), 0);
    checkOutput("t1DoneReadNext", rnCount, 1);

    // 24x8: two MCUs, right half and bottom half clipped
    applyStimulus(24, 8, 3);
    checkOutput("t2ModelSize", expQ.size(), 192);
    waitDone(2000);
    checkOutput("t2Pixels", acceptCount, 192);
    checkOutput("t2ReadNextCount", rnCount, 2);
    checkOutput("t2LastCount", lastCount, 1);
    checkOutput("t2LastX", lastX, 23);
    checkOutput("t2LastY", lastY, 7);

    // 40x20 with a 50% ready consumer
    readyRandom = 1;
    applyStimulus(40, 20, 3);
    checkOutput("t3ModelSize", expQ.size(), 800);
    waitDone(8000);
    checkOutput("t3Pixels", acceptCount, 800);
    checkOutput("t3ReadNextCount", rnCount, 6);
    checkOutput("t3LastX", lastX, 39);
    checkOutput("t3LastY", lastY, 19);

    // Grayscale 24x24 with random ready: chroma forced to 128
    applyStimulus(24, 24, 1);
    waitDone(6000);
    checkOutput("t4Pixels", acceptCount, 576);
    checkOutput("t4ReadNextCount", rnCount, 4);
    checkOutput("t4LastX", lastX, 23);
    checkOutput("t4LastY", lastY, 23);
    readyRandom = 0;

    // 32x16 with DataOutEnable withdrawn for 10 cycles between MCUs
    applyStimulus(32, 16, 3);
    gotRn = 0;
    for (int i = 0; i < 1000 && !gotRn; i++) begin
      @(negedge clk);
      if (bus.DataOutReadNext) gotRn = 1;
    end
    checkOutput("t5FirstRelease", int'(gotRn), 1);
    bus.DataOutEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t5IdleBusy", int'(Busy), 0);
      checkOutput("t5IdleRead", int'(bus.DataOutRead), 0);
    end
    bus.DataOutEnable = 1'b1;
    waitDone(2000);
    checkOutput("t5Pixels", acceptCount, 512);
    checkOutput("t5ReadNextCount", rnCount, 2);
    checkOutput("t5LastX", lastX, 31);
    checkOutput("t5LastY", lastY, 15);

    // Restart in the middle of an MCU (counter at 100), then a full 32x32
    applyStimulus(32, 32, 3);
    reads = 0;
    for (int i = 0; i < 1000 && reads < 100; i++) begin
      @(negedge clk);
      if (bus.DataOutRead) reads++;
    end
    checkOutput("t6ReachedCnt100", reads, 100);
    applyStimulus(32, 32, 3);
    @(negedge clk);
    checkOutput("t6InitOutEnable", int'(bus.OutEnable), 0);
    checkOutput("t6InitBusy", int'(Busy), 0);
    checkOutput("t6ModelSize", expQ.size(), 1024);
    waitDone(3000);
    checkOutput("t6Pixels", acceptCount, 1024);
    checkOutput("t6ReadNextCount", rnCount, 4);
    checkOutput("t6LastCount", lastCount, 1);
    checkOutput("t6LastX", lastX, 31);
    checkOutput("t6LastY", lastY, 31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aq_djpeg_ycbcr_reader.md
# aq_djpeg_ycbcr_reader

Read-side sequencer for the YCbCr MCU buffer of the JPEG decoder. It waits for a filled bank, walks the 16x16 MCU in raster order by driving the buffer's Y and CbCr read addresses, and streams pixels with image coordinates over a ready/valid interface to the colour-conversion stage. It clips pixels outside the image and releases each bank with a one-cycle `DataOutReadNext` pulse.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `DataInit`  in  1  synchronous restart for a new image; priority over all other inputs
- `JpegComp`  in  3  component count: 3 = YCbCr 4:2:0, 1 = grayscale
- `ImageWidth`  in  16  image width in pixels, 1..65535, stable between `DataInit` pulses
- `ImageHeight`  in  16  image height in pixels, 1..65535, stable between `DataInit` pulses
- `DataOutEnable`  in  1  buffer holds at least one filled bank
- `DataOutAddressY`  out  8  Y sample address, {row[3:0], col[3:0]}
- `DataOutAddressCbCr`  out  8  CbCr address, {row[3:0], col[3:0]}; the buffer subsamples internally
- `DataOutRead`  out  1  buffer read-register enable
- `DataOutReadNext`  out  1  one-cycle pulse releasing the current bank
- `DataOutY`, `DataOutCb`, `DataOutCr`  in  9 each  buffer read data, one cycle after `DataOutRead`
- `OutEnable`  out  1  pixel valid
- `OutReady`  in  1  downstream accepts the pixel
- `OutPixelX`, `OutPixelY`  out  16 each  pixel coordinates in the image
- `OutY`, `OutCb`, `OutCr`  out  9 each  pixel samples
- `OutLast`  out  1  qualifies the pixel at (ImageWidth-1, ImageHeight-1)
- `Busy`  out  1  high in every state except S_IDLE and S_DONE

## Operation
- State machine has four states:
  - S_IDLE: if `DataOutEnable`, go to S_RUN and set Cnt = 0.
  - S_RUN: issue one address per advance. When the advance takes Cnt = 255, go to S_DRAIN.
  - S_DRAIN: when advance holds, pulse `DataOutReadNext`, clear RdValid and step the MCU position. Then go to S_IDLE, or to S_DONE if this was the last MCU.
  - S_DONE: hold until `DataInit`.
- Advance = !RdValid | OutReady | RdClip.
- Issue = (state == S_RUN) & advance. `DataOutRead` = Issue.
- Addresses are driven combinationally from the 8-bit Cnt: row = Cnt[7:4], col = Cnt[3:0].
- Issue sets RdValid. RdValid is cleared on advance with no issue.
- With each issue, register the pixel tag: PX = McuX*16 + col, PY = McuY*16 + row. Also register RdClip = (PX >= ImageWidth) | (PY >= ImageHeight).
- `OutEnable` = RdValid & !RdClip. Clipped pixels are dropped without waiting for `OutReady`.
- `OutY` = `DataOutY`.
- `OutCb` and `OutCr` = `DataOutCb` and `DataOutCr`; when `JpegComp` == 1 both are forced to 9'd128.
- MCU step: if (McuX+1)*16 >= ImageWidth, then McuX = 0 and McuY += 1; otherwise McuX += 1.
- The last MCU is the one where both (McuX+1)*16 >= ImageWidth and (McuY+1)*16 >= ImageHeight.
- McuX and McuY are 12-bit. Comparisons use 17-bit arithmetic, so there is no wrap.
- `DataInit`:
  - Forces S_IDLE, Cnt = 0, McuX = McuY = 0, RdValid = 0.
  - Suppresses `DataOutReadNext` in that cycle.
  - A bank is never released mid-MCU; the buffer is reset by the same `DataInit`.

## Timing
- Reset values:
  - state S_IDLE; Cnt, McuX, McuY, RdValid, RdClip all 0.
  - `DataOutRead`, `DataOutReadNext`, `OutEnable`, `OutLast`, `Busy` = 0.
  - `OutPixelX`, `OutPixelY` = 0; addresses = 0.
- Latency: issue at cycle t gives `OutEnable`/data at t+1. The pixel is held stable, with `DataOutRead` low, until `OutReady`.
- Throughput: 1 pixel/clk with `OutReady` high.
- MCU period with continuous `DataOutEnable` and `OutReady` is 258 cycles: 1 S_IDLE + 256 S_RUN + 1 S_DRAIN.
- Bank handoff:
  - `DataOutReadNext` is asserted in exactly one cycle per MCU, in the same cycle the final pixel is accepted or dropped.
  - S_IDLE samples `DataOutEnable` on the following cycle, after the buffer's read bank has updated.
- Simultaneous `OutReady` and Issue: the held pixel is consumed and the new read data loads in the same edge; no bubble.
- `OutReady` is ignored while `OutEnable` is low.

## Test plan
- 16x16 YCbCr image, `OutReady` = 1:
  - 256 pixels in raster order, X = Cnt[3:0], Y = Cnt[7:4].
  - One `DataOutReadNext` pulse, at cycle 257.
  - `OutLast` on pixel (15,15); final state S_DONE.
- 24x8 image:
  - Two MCUs; only X < 24, Y < 8 emitted, 192 pixels total.
  - Second MCU emits X 16..23 only.
  - `OutLast` on (23,7).
- Random `OutReady` (50%):
  - Each held pixel's data and coordinates stay stable until accepted.
  - No pixel is lost or duplicated against a scoreboard.
- `JpegComp` = 1: `OutCb` = `OutCr` = 128 on all pixels; Y matches the buffer model.
- `DataOutEnable` low for 10 cycles between MCUs: state stays S_IDLE, no `DataOutRead`; resumes on assertion.
- `DataInit` at Cnt = 100:
  - Next cycle state S_IDLE, `OutEnable` = 0, no `DataOutReadNext`.
  - A new 32x32 image then emits 1024 pixels across 4 MCUs.
  - `OutLast` on (31,31).
